// File: rtl/alu_wrapper.sv
// ============================================================================
// alu_wrapper : 64-bit Y86-64 execute ALU (add/sub/and/xor) with ZF/SF/OF CC register
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_wrapper (
  output logic        of,
  output logic [63:0] out,
  input  logic [1:0]  alu_fun,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        clk,
  input  logic        reset,
  input  logic        cc_en,
  output logic        zf_q,
  output logic        sf_q,
  output logic        of_q
);

  localparam logic [1:0] FUN_ADD = 2'd0;
  localparam logic [1:0] FUN_SUB = 2'd1;
  localparam logic [1:0] FUN_AND = 2'd2;
  localparam logic [1:0] FUN_XOR = 2'd3;

  logic        is_sub;
  logic [63:0] b_eff;
  logic [63:0] sum;
  logic        zf_next;

  // Subtraction reuses the adder as a + ~b + 1, so the result is a - b.
  assign is_sub = (alu_fun == FUN_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = a + b_eff + {63'd0, is_sub};

  always_comb begin
    out = sum;
    of  = 1'b0;
    case (alu_fun)
      FUN_ADD: begin
        out = sum;
        of  = (a[63] == b[63]) && (sum[63] != a[63]);
      end
      FUN_SUB: begin
        out = sum;
        of  = (a[63] != b[63]) && (sum[63] != a[63]);
      end
      FUN_AND: out = a & b;
      FUN_XOR: out = a ^ b;
      default: begin
        out = sum;
        of  = 1'b0;
      end
    endcase
  end

  assign zf_next = (out == 64'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_en) begin
      zf_q <= zf_next;
      sf_q <= out[63];
      of_q <= of;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_wrapper.sv
// ============================================================================
// tb_alu_wrapper : directed self-checking bench for alu_wrapper
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_alu_wrapper;

  logic        of;
  logic [63:0] out;
  logic [1:0]  alu_fun;
  logic [63:0] a;
  logic [63:0] b;
  logic        clk;
  logic        reset;
  logic        cc_en;
  logic        zf_q;
  logic        sf_q;
  logic        of_q;

  int checks   = 0;
  int failures = 0;

  alu_wrapper dut (
    .of      (of),
    .out     (out),
    .alu_fun (alu_fun),
    .a       (a),
    .b       (b),
    .clk     (clk),
    .reset   (reset),
    .cc_en   (cc_en),
    .zf_q    (zf_q),
    .sf_q    (sf_q),
    .of_q    (of_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] f, input logic [63:0] va, input logic [63:0] vb);
    alu_fun = f;
    a       = va;
    b       = vb;
    #1;
  endtask

  // One rising edge with the given cc_en; returns 1 time unit after the edge.
  task automatic edge_cc(input logic en);
    cc_en = en;
    @(posedge clk);
    #1;
    cc_en = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic ez, input logic es, input logic eo);
    chk({tag, "_zf"}, {63'd0, zf_q}, {63'd0, ez});
    chk({tag, "_sf"}, {63'd0, sf_q}, {63'd0, es});
    chk({tag, "_of"}, {63'd0, of_q}, {63'd0, eo});
  endtask

  initial begin
    reset   = 1'b1;
    cc_en   = 1'b0;
    alu_fun = 2'd0;
    a       = 64'd0;
    b       = 64'd0;
    #1;
    chk_flags("reset", 1'b0, 1'b0, 1'b0);

    // Reset dominates cc_en across an edge.
    drive(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    edge_cc(1'b1);
    chk_flags("rst_over_en", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    edge_cc(1'b0);
    chk_flags("post_release", 1'b0, 1'b0, 1'b0);

    // Add wrap with overflow
    drive(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    chk("add_wrap_out", out, 64'h8000_0000_0000_0000);
    chk("add_wrap_of", {63'd0, of}, 64'd1);
    edge_cc(1'b1);
    chk_flags("add_wrap", 1'b0, 1'b1, 1'b1);

    // Sub to zero
    drive(2'd1, 64'd5, 64'd5);
    chk("sub_zero_out", out, 64'd0);
    chk("sub_zero_of", {63'd0, of}, 64'd0);
    edge_cc(1'b1);
    chk_flags("sub_zero", 1'b1, 1'b0, 1'b0);

    // Sub operand order: a - b = 3 - 5
    drive(2'd1, 64'd3, 64'd5);
    chk("sub_neg_out", out, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_neg_of", {63'd0, of}, 64'd0);
    edge_cc(1'b1);
    chk_flags("sub_neg", 1'b0, 1'b1, 1'b0);

    // Sub overflow
    drive(2'd1, 64'h8000_0000_0000_0000, 64'd1);
    chk("sub_ovf_out", out, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_ovf_of", {63'd0, of}, 64'd1);
    edge_cc(1'b1);
    chk_flags("sub_ovf", 1'b0, 1'b0, 1'b1);

    // Logic ops
    drive(2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    chk("and_out", out, 64'hF000_F000_F000_F000);
    chk("and_of", {63'd0, of}, 64'd0);
    drive(2'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    chk("xor_out", out, 64'h0FF0_0FF0_0FF0_0FF0);
    chk("xor_of", {63'd0, of}, 64'd0);

    // Hold: zero result with cc_en low leaves the sub_ovf flags in place
    drive(2'd1, 64'd5, 64'd5);
    for (int i = 0; i < 3; i++) begin
      edge_cc(1'b0);
      chk_flags("hold_zero", 1'b0, 1'b0, 1'b1);
    end
    drive(2'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("sp_out", out, 64'hF8);
    chk("sp_of", {63'd0, of}, 64'd0);
    edge_cc(1'b0);
    chk_flags("sp_hold", 1'b0, 1'b0, 1'b1);

    // Flags also load from logic ops
    drive(2'd3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    edge_cc(1'b1);
    chk_flags("xor_zero", 1'b1, 1'b0, 1'b0);

    // Async reset between edges; datapath keeps computing
    drive(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    edge_cc(1'b1);
    chk_flags("pre_reset", 1'b0, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_flags("async_reset", 1'b0, 1'b0, 1'b0);
    drive(2'd0, 64'd2, 64'd3);
    chk("reset_out", out, 64'd5);
    reset = 1'b0;
    edge_cc(1'b0);
    chk_flags("after_reset_hold", 1'b0, 1'b0, 1'b0);
    drive(2'd1, 64'd0, 64'd1);
    chk("sub_m1_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
    edge_cc(1'b1);
    chk_flags("first_en_after_reset", 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
